exception_ctrl: RTL

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exc_pkg.sv | 31 +++
 rtl/exception_ctrl_if.sv | 39 +++
 rtl/exc_prio_enc.sv | 29 ++
 rtl/exception_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg
// Shared definitions for the exception controller slice.
//   excState_t       : controller state encoding
//   EXC_OVERFLOW     : cause index of arithmetic overflow
//   EXC_OPCODE       : cause index of invalid opcode
//   DEFAULT_VEC_BASE : default byte address of the vector table
//   causeWidth()     : index width for a given cause count (never below 1)
// ---------------------------------------------------------------------------
package exc_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      WAIT    = 3'd2,
      JUMP    = 3'd3,
      HANDLER = 3'd4,
      RETURN  = 3'd5
   } excState_t;

   localparam int EXC_OVERFLOW = 0;
   localparam int EXC_OPCODE   = 1;

   localparam logic [31:0] DEFAULT_VEC_BASE = 32'd252;

   // A single cause still needs a one-bit index so the cause register exists.
   function automatic int causeWidth(input int numCauses);
      return (numCauses <= 1) ? 1 : $clog2(numCauses);
   endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// ---------------------------------------------------------------------------
// exception_ctrl_if
// Bundles the exception controller's request, memory and PC-control signals.
//   master : CPU/memory side (drives requests, rfe, enable writes, read data)
//   slave  : exception controller (drives vector reads, PC loads, status)
// ---------------------------------------------------------------------------
interface exception_ctrl_if #(
   parameter int WIDTH      = 32,
   parameter int NUM_CAUSES = 4
);

   logic [NUM_CAUSES-1:0] exc_req;
   logic [WIDTH-1:0]      exc_pc;
   logic                  rfe;
   logic                  en_we;
   logic [NUM_CAUSES-1:0] en_data;
   logic [WIDTH-1:0]      mem_rdata;

   logic                  vec_rd;
   logic [WIDTH-1:0]      vec_addr;
   logic                  pc_load;
   logic [WIDTH-1:0]      pc_value;
   logic                  stall;
   logic                  in_exc;
   logic [WIDTH-1:0]      epc;
   logic [WIDTH-1:0]      cause;
   logic [NUM_CAUSES-1:0] pending;

   modport master (
      output exc_req, exc_pc, rfe, en_we, en_data, mem_rdata,
      input  vec_rd, vec_addr, pc_load, pc_value, stall, in_exc, epc, cause, pending
   );

   modport slave (
      input  exc_req, exc_pc, rfe, en_we, en_data, mem_rdata,
      output vec_rd, vec_addr, pc_load, pc_value, stall, in_exc, epc, cause, pending
   );

endinterface

// File: rtl/exc_prio_enc.sv
// ---------------------------------------------------------------------------
// exc_prio_enc
// Lowest-index-wins priority encoder.
//   requests : candidate request vector
//   valid    : at least one request bit set
//   index    : position of the lowest set bit (0 when none)
// ---------------------------------------------------------------------------
module exc_prio_enc #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  requests,
   output logic          valid,
   output logic [IW-1:0] index
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (requests[i]) begin
            valid = 1'b1;
            index = IW'(i);
         end
      end
   end

endmodule

// File: rtl/exception_ctrl.sv
// ---------------------------------------------------------------------------
// exception_ctrl
// Accepts exception requests, fetches the handler address from a vector
// table, redirects the PC to it and later returns to the faulting PC.
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : exception_ctrl_if.slave (requests, enable writes, vector memory
//           read, PC load, stall, in_exc, epc, cause, pending)
// ---------------------------------------------------------------------------
module exception_ctrl
   import exc_pkg::*;
#(
   parameter int                    WIDTH      = 32,
   parameter int                    NUM_CAUSES = 4,
   parameter logic [WIDTH-1:0]      VEC_BASE   = WIDTH'(DEFAULT_VEC_BASE),
   parameter int                    MEM_LAT    = 1,
   parameter logic [NUM_CAUSES-1:0] EN_RESET   = '1
) (
   input  logic             clock,
   input  logic             reset,
   exception_ctrl_if.slave  bus
);

   localparam int         CW       = causeWidth(NUM_CAUSES);
   localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

   excState_t             rState;
   logic [NUM_CAUSES-1:0] rPending;
   logic [NUM_CAUSES-1:0] rEnable;
   logic [WIDTH-1:0]      rEpc;
   logic [CW-1:0]         rCause;
   logic [WIDTH-1:0]      rHandler;
   logic [1:0]            rWaitCnt;

   logic [NUM_CAUSES-1:0] wCandidates;
   logic                  wCandValid;
   logic [CW-1:0]         wCandIndex;
   logic                  wAccept;
   logic [NUM_CAUSES-1:0] wAcceptMask;
   logic [WIDTH-1:0]      wVecAddr;

   // Requests arriving this cycle compete alongside the sticky ones.
   assign wCandidates = (rPending | bus.exc_req) & rEnable;
   assign wAccept     = (rState == IDLE) && wCandValid;
   assign wAcceptMask = wAccept ? (NUM_CAUSES'(1) << wCandIndex) : '0;
   assign wVecAddr    = VEC_BASE + (WIDTH'(rCause) << 2);

   exc_prio_enc #(
      .N  (NUM_CAUSES),
      .IW (CW)
   ) prioEnc (
      .requests (wCandidates),
      .valid    (wCandValid),
      .index    (wCandIndex)
   );

   // Pending bits accumulate every cycle and only the accepted bit is dropped;
   // enable writes land on the next edge regardless of controller state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rPending <= '0;
         rEnable  <= EN_RESET;
      end else begin
         rPending <= (rPending | bus.exc_req) & ~wAcceptMask;
         if (bus.en_we) begin
            rEnable <= bus.en_data;
         end
      end
   end

   // Sequencer: accept in IDLE, read the vector entry, jump, run the handler
   // until rfe, then return to the saved PC. epc/cause only change on accept.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rState   <= IDLE;
         rEpc     <= '0;
         rCause   <= '0;
         rHandler <= '0;
         rWaitCnt <= '0;
      end else begin
         case (rState)
            IDLE: begin
               if (wAccept) begin
                  rEpc   <= bus.exc_pc;
                  rCause <= wCandIndex;
                  rState <= FETCH;
               end
            end
            FETCH: begin
               rWaitCnt <= '0;
               rState   <= WAIT;
            end
            WAIT: begin
               if (rWaitCnt == LAST_CNT) begin
                  rHandler <= bus.mem_rdata;
                  rState   <= JUMP;
               end else begin
                  rWaitCnt <= rWaitCnt + 2'd1;
               end
            end
            JUMP: begin
               rState <= HANDLER;
            end
            HANDLER: begin
               if (bus.rfe) begin
                  rState <= RETURN;
               end
            end
            RETURN: begin
               rState <= IDLE;
            end
            default: begin
               rState <= IDLE;
            end
         endcase
      end
   end

   // Strobes and their data buses are decoded purely from the state so the
   // data lines read zero whenever their strobe is low.
   always_comb begin
      bus.vec_rd   = 1'b0;
      bus.vec_addr = '0;
      bus.pc_load  = 1'b0;
      bus.pc_value = '0;
      bus.stall    = 1'b0;
      bus.in_exc   = 1'b0;
      case (rState)
         FETCH, WAIT: begin
            bus.vec_rd   = 1'b1;
            bus.vec_addr = wVecAddr;
            bus.stall    = 1'b1;
         end
         JUMP: begin
            bus.pc_load  = 1'b1;
            bus.pc_value = rHandler;
            bus.stall    = 1'b1;
         end
         RETURN: begin
            bus.pc_load  = 1'b1;
            bus.pc_value = rEpc;
            bus.stall    = 1'b1;
         end
         HANDLER: begin
            bus.in_exc = 1'b1;
         end
         default: begin
            bus.stall = 1'b0;
         end
      endcase
   end

   assign bus.epc     = rEpc;
   assign bus.cause   = WIDTH'(rCause);
   assign bus.pending = rPending;

endmodule
